bram_frame_reader: RTL
======================

BRAM_FRAME_READER -- requirements
Module: bram_frame_reader

Interface
REQ-001 SHALL have parameter N, default 13, meaning BRAM address width.
REQ-002 SHALL have parameter W, default 16, meaning pixel/data width (RGB565).
REQ-003 SHALL have parameter NUM_PIX, default 6144, meaning pixels per frame (96x64), with NUM_PIX <= 2**N.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request one frame read, sampled while idle.
REQ-007 SHALL have port bram_addr, output, N bits: registered read address to the BRAM.
REQ-008 SHALL have port bram_read_write, output, 1 bit: BRAM write enable, constant 0.
REQ-009 SHALL have port bram_clear, output, 1 bit: BRAM clear, constant 0.
REQ-010 SHALL have port bram_data_out, input, W bits: BRAM read data, valid 1 cycle after the address.
REQ-011 SHALL have port pix_data, output, W bits: output pixel.
REQ-012 SHALL have port pix_valid, output, 1 bit: pix_data is valid.
REQ-013 SHALL have port pix_ready, input, 1 bit: downstream accepts the pixel.
REQ-014 SHALL have port pix_last, output, 1 bit: marks pixel NUM_PIX-1, qualified by pix_valid.
REQ-015 SHALL have port busy, output, 1 bit: high from start acceptance until frame completion.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-017 SHALL implement states IDLE, FETCH and DRAIN; IDLE->FETCH on start=1, FETCH->DRAIN after address NUM_PIX-1 is issued, DRAIN->IDLE on handshake of the pix_last pixel.
REQ-018 SHALL, on the edge accepting start, set bram_addr=0 and busy=1.
REQ-019 SHALL count a read as issued on each FETCH cycle whose issue condition holds; bram_addr then increments by 1 on that edge.
REQ-020 SHALL issue addresses strictly 0..NUM_PIX-1 in order, with no wrap and no repeat within a frame.
REQ-021 SHALL capture bram_data_out exactly one cycle after the corresponding address was issued, into a 2-entry output FIFO.
REQ-022 SHALL issue a read only when FIFO occupancy plus in-flight reads < 2, so that no captured pixel is ever dropped.
REQ-023 SHALL present the FIFO head on pix_data/pix_valid; a handshake occurs when pix_valid&&pix_ready.
REQ-024 SHALL hold pix_data and pix_last stable while pix_valid=1 and pix_ready=0.
REQ-025 SHALL, with pix_ready held at 1, sustain 1 pixel per cycle after an initial latency of 2 cycles from start acceptance to first pix_valid.
REQ-026 SHALL assert pix_last only with pixel index NUM_PIX-1.
REQ-027 SHALL, on the handshake of the last pixel, deassert busy, return to IDLE and pulse done for exactly the next cycle.
REQ-028 SHALL ignore start while busy=1, including when start coincides with the done cycle.
REQ-029 SHALL accept start in the cycle after done (back-to-back frames).
REQ-030 SHALL, at FIFO full with a simultaneous pop and capture, keep occupancy unchanged and preserve order.

Reset
REQ-031 SHALL, on rst_n=0, immediately set state=IDLE, bram_addr=0, pix_valid=0, pix_last=0, busy=0, done=0, FIFO empty and in-flight count 0.
REQ-032 SHALL, on reset mid-frame, abandon the frame with no done pulse; the next start restarts from address 0.
REQ-033 SHALL drive pix_data=0 after reset until the first capture.

Verification
REQ-034 SHALL verify a full frame with pix_ready=1 and BRAM preloaded with data=address: pixels 0..6143 in order, pix_last on 6143, done pulse one cycle later, 6144+2 cycles start-to-last.
REQ-035 SHALL verify random pix_ready (50% duty): identical 6144-pixel sequence, none lost or duplicated, pix_data stable during stalls.
REQ-036 SHALL verify pix_ready=0 for 20 cycles after start: bram_addr stops at 2 and pix_data=0 is held; on release the stream resumes with 1, 2, ...
REQ-037 SHALL verify rst_n pulsed low at pixel 3000: outputs go to reset values at once with no done; a new start streams from 0.
REQ-038 SHALL verify start asserted while busy and during the done cycle: ignored; start in the next cycle begins frame 2 from address 0.
REQ-039 SHALL verify NUM_PIX=4 with N=2: addresses 0,1,2,3, pix_last on the 4th pixel, and bram_read_write=0 and bram_clear=0 throughout.

Source files
------------

// File: rtl/bram_frame_reader.sv
// rtl/bram_frame_reader.sv - streams one frame of pixels from a registered-read BRAM into a ready/valid pixel port

// Two-entry output queue holding {last, data}; write into the head slot is legal only when the head is popped in the same cycle
module bram_frame_reader_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 until the first capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module bram_frame_reader #(
  parameter int N       = 13,
  parameter int W       = 16,
  parameter int NUM_PIX = 6144
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] bram_addr,
  output logic         bram_read_write,
  output logic         bram_clear,
  input  logic [W-1:0] bram_data_out,
  output logic [W-1:0] pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_last,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0]   S_IDLE    = 2'd0;
  localparam logic [1:0]   S_FETCH   = 2'd1;
  localparam logic [1:0]   S_DRAIN   = 2'd2;
  localparam logic [N-1:0] LAST_ADDR = N'(NUM_PIX - 1);

  logic [1:0] state;
  logic       rd_pending;
  logic       rd_pending_last;
  logic [1:0] fifo_count;
  logic [W:0] fifo_head;
  logic       accept;
  logic       pop;
  logic       issue;
  logic       issue_last;
  logic       last_hs;

  // The reader never writes or clears the BRAM
  assign bram_read_write = 1'b0;
  assign bram_clear      = 1'b0;

  // A start coinciding with the done pulse is dropped so every frame gets a distinct start
  assign accept = (state == S_IDLE) && start && !done;
  assign pop    = pix_valid && pix_ready;

  // Occupancy plus the read in flight must stay within the two slots; a pop this cycle frees one,
  // which is what lets the stream run at one pixel per cycle
  assign issue      = (state == S_FETCH) &&
                      (({1'b0, fifo_count} + {2'b00, rd_pending}) < (3'd2 + {2'b00, pop}));
  assign issue_last = issue && (bram_addr == LAST_ADDR);
  assign last_hs    = pop && fifo_head[W];

  assign pix_valid = (fifo_count != 2'd0);
  assign pix_data  = fifo_head[W-1:0];
  assign pix_last  = fifo_head[W] && pix_valid;

  // Frame sequencing: busy spans start acceptance to the last handshake, done pulses the cycle after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (issue_last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_hs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read address: restarts at 0 on each frame and parks on the final address so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr <= '0;
    end else if (accept) begin
      bram_addr <= '0;
    end else if (issue && !issue_last) begin
      bram_addr <= bram_addr + 1'b1;
    end
  end

  // One-cycle read pipeline marker: data for an issued address arrives on the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
    end else begin
      rd_pending      <= issue;
      rd_pending_last <= issue_last;
    end
  end

  bram_frame_reader_fifo #(
    .W (W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pending),
    .push_data ({rd_pending_last, bram_data_out}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule
